// File: rtl/assoc_cache_pkg.sv
// Shared types and default geometry for the set-associative lookup cache.
package assoc_cache_pkg;

  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_DATA_W   = 64;
  localparam int DEF_NUM_SETS = 16;
  localparam int DEF_NUM_WAYS = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL,
    S_FLUSH
  } state_t;

endpackage

// File: rtl/assoc_cache_lru.sv
// Combinational LRU helper for one set: age update for an accessed way and
// victim choice (lowest invalid way first, otherwise the oldest way).
module assoc_cache_lru #(
  parameter int NUM_WAYS = 2,
  parameter int AGE_W    = 1
) (
  input  logic [NUM_WAYS*AGE_W-1:0] i_ages,
  input  logic [NUM_WAYS-1:0]       i_valid,
  input  logic [AGE_W-1:0]          i_way,
  output logic [NUM_WAYS*AGE_W-1:0] o_ages,
  output logic [AGE_W-1:0]          o_victim
);

  logic [AGE_W-1:0] w_oldAge;

  assign w_oldAge = i_ages[i_way*AGE_W +: AGE_W];

  always_comb begin : p_age
    o_ages = i_ages;
    for (int v = 0; v < NUM_WAYS; v++) begin
      if (AGE_W'(v) == i_way) begin
        o_ages[v*AGE_W +: AGE_W] = '0;
      end else if (i_ages[v*AGE_W +: AGE_W] < w_oldAge) begin
        o_ages[v*AGE_W +: AGE_W] = i_ages[v*AGE_W +: AGE_W] + 1'b1;
      end
    end
  end

  always_comb begin : p_victim
    logic found;
    found    = 1'b0;
    o_victim = '0;
    for (int v = 0; v < NUM_WAYS; v++) begin
      if (!found && !i_valid[v]) begin
        o_victim = AGE_W'(v);
        found    = 1'b1;
      end
    end
    // Ages form a permutation, so exactly one way carries the maximum age.
    if (!found) begin
      for (int v = 0; v < NUM_WAYS; v++) begin
        if (i_ages[v*AGE_W +: AGE_W] == AGE_W'(NUM_WAYS - 1)) begin
          o_victim = AGE_W'(v);
        end
      end
    end
  end

endmodule

// File: rtl/assoc_cache.sv
// Set-associative read cache with LRU replacement, a single-word refill
// handshake to main memory, a sequential flush and saturating hit/miss counters.
module assoc_cache
  import assoc_cache_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_SETS = DEF_NUM_SETS,
  parameter int NUM_WAYS = DEF_NUM_WAYS
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                search_cache,
  input  logic [ADDR_W-1:0]                   address,
  input  logic                                flush,
  output logic                                ready,
  output logic                                search_done,
  output logic                                hit,
  output logic [DATA_W-1:0]                   data,
  output logic [ADDR_W-$clog2(NUM_SETS)-1:0]  tag_out,
  output logic                                mem_req,
  output logic [ADDR_W-1:0]                   RAM_address,
  input  logic [DATA_W-1:0]                   main_memory_data,
  input  logic                                mem_ack,
  output logic [31:0]                         hit_count,
  output logic [31:0]                         miss_count
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [IDX_W-1:0]    r_flushIdx;
  logic [WAY_W-1:0]    r_victim;
  logic [NUM_WAYS-1:0] r_valid   [NUM_SETS];
  logic [TAG_W-1:0]    r_tagArr  [NUM_SETS][NUM_WAYS];
  logic [DATA_W-1:0]   r_dataArr [NUM_SETS][NUM_WAYS];

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic [WAY_W-1:0] w_hitWay;
  logic [WAY_W-1:0] w_victim;
  logic             w_fill;

  assign w_idx  = r_addr[IDX_W-1:0];
  assign w_tag  = r_addr[ADDR_W-1:IDX_W];
  assign w_fill = (r_state == S_REFILL) && mem_ack;
  assign ready  = (r_state == S_IDLE);

  always_comb begin
    w_hit    = 1'b0;
    w_hitWay = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_idx][w] && (r_tagArr[w_idx][w] == w_tag)) begin
        w_hit    = 1'b1;
        w_hitWay = WAY_W'(w);
      end
    end
  end

  // Line storage carries no reset; valid bits alone decide whether it is used.
  always_ff @(posedge clock) begin
    if (w_fill) begin
      r_tagArr[w_idx][r_victim]  <= w_tag;
      r_dataArr[w_idx][r_victim] <= main_memory_data;
    end
  end

  generate
    if (NUM_WAYS > 1) begin : g_lru
      localparam int AGES_W = NUM_WAYS * WAY_W;
      logic [AGES_W-1:0] r_age [NUM_SETS];
      logic [AGES_W-1:0] w_initAges;
      logic [AGES_W-1:0] w_newAges;
      logic [WAY_W-1:0]  w_accWay;

      for (genvar g = 0; g < NUM_WAYS; g++) begin : g_init
        assign w_initAges[g*WAY_W +: WAY_W] = WAY_W'(g);
      end

      assign w_accWay = (r_state == S_LOOKUP) ? w_hitWay : r_victim;

      assoc_cache_lru #(
        .NUM_WAYS(NUM_WAYS),
        .AGE_W   (WAY_W)
      ) u_lru (
        .i_ages  (r_age[w_idx]),
        .i_valid (r_valid[w_idx]),
        .i_way   (w_accWay),
        .o_ages  (w_newAges),
        .o_victim(w_victim)
      );

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          for (int s = 0; s < NUM_SETS; s++) r_age[s] <= w_initAges;
        end else if (r_state == S_FLUSH) begin
          r_age[r_flushIdx] <= w_initAges;
        end else if (((r_state == S_LOOKUP) && w_hit) || w_fill) begin
          r_age[w_idx] <= w_newAges;
        end
      end
    end else begin : g_dm
      assign w_victim = '0;
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_flushIdx  <= '0;
      r_victim    <= '0;
      for (int s = 0; s < NUM_SETS; s++) r_valid[s] <= '0;
      search_done <= 1'b0;
      hit         <= 1'b0;
      data        <= '0;
      tag_out     <= '0;
      mem_req     <= 1'b0;
      RAM_address <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      search_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (flush) begin
            r_state    <= S_FLUSH;
            r_flushIdx <= '0;
          end else if (search_cache) begin
            r_state <= S_LOOKUP;
            r_addr  <= address;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            search_done <= 1'b1;
            hit         <= 1'b1;
            data        <= r_dataArr[w_idx][w_hitWay];
            tag_out     <= w_tag;
            if (hit_count != '1) hit_count <= hit_count + 32'd1;
            r_state     <= S_IDLE;
          end else begin
            r_victim    <= w_victim;
            mem_req     <= 1'b1;
            RAM_address <= r_addr;
            r_state     <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (mem_ack) begin
            r_valid[w_idx][r_victim] <= 1'b1;
            mem_req     <= 1'b0;
            search_done <= 1'b1;
            hit         <= 1'b0;
            data        <= main_memory_data;
            tag_out     <= w_tag;
            if (miss_count != '1) miss_count <= miss_count + 32'd1;
            r_state     <= S_IDLE;
          end
        end
        S_FLUSH: begin
          r_valid[r_flushIdx] <= '0;
          r_flushIdx          <= r_flushIdx + 1'b1;
          if (r_flushIdx == IDX_W'(NUM_SETS - 1)) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_assoc_cache.sv
// Self-checking bench for assoc_cache: an LRU-list model per set predicts every
// lookup, and a per-cycle compare process checks the DUT outputs against it.
module tb_assoc_cache;

  localparam int NUM_WAYS = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        search_cache = 1'b0;
  logic [31:0] address = '0;
  logic        flush = 1'b0;
  logic        ready;
  logic        search_done;
  logic        hit;
  logic [63:0] data;
  logic [27:0] tag_out;
  logic        mem_req;
  logic [31:0] RAM_address;
  logic [63:0] main_memory_data = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  assoc_cache #(
    .ADDR_W  (32),
    .DATA_W  (64),
    .NUM_SETS(16),
    .NUM_WAYS(NUM_WAYS)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .search_cache    (search_cache),
    .address         (address),
    .flush           (flush),
    .ready           (ready),
    .search_done     (search_done),
    .hit             (hit),
    .data            (data),
    .tag_out         (tag_out),
    .mem_req         (mem_req),
    .RAM_address     (RAM_address),
    .main_memory_data(main_memory_data),
    .mem_ack         (mem_ack),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  typedef struct {
    logic [31:0] addr;
    bit          hit;
    int          acceptCyc;
    int          delay;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          ackDelay = 1;
  exp_t        expQ[$];
  logic [27:0] setTags [16][$];
  logic        lastHit = 1'b0;
  logic [63:0] lastData = '0;
  logic [27:0] lastTag = '0;
  int          modelHits = 0;
  int          modelMisses = 0;

  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  function automatic logic [63:0] memWord(input logic [31:0] a);
    return {32'd0, a} * {32'd0, a};
  endfunction

  // MRU-first tag list per set; capacity NUM_WAYS, oldest entry falls off the end.
  function automatic bit modelAccess(input logic [31:0] a);
    int          s;
    logic [27:0] t;
    s = int'(a[3:0]);
    t = a[31:4];
    for (int i = 0; i < setTags[s].size(); i++) begin
      if (setTags[s][i] == t) begin
        setTags[s].delete(i);
        setTags[s].push_front(t);
        return 1'b1;
      end
    end
    if (setTags[s].size() >= NUM_WAYS) void'(setTags[s].pop_back());
    setTags[s].push_front(t);
    return 1'b0;
  endfunction

  function automatic void modelClear();
    for (int s = 0; s < 16; s++) setTags[s].delete();
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder: acks after ackDelay cycles of mem_req with word[i]=i*i.
  initial forever begin
    int reqCycles;
    @(negedge clock);
    if (mem_ack) begin
      mem_ack = 1'b0;
      reqCycles = 0;
    end else if (mem_req) begin
      reqCycles++;
      if (reqCycles >= ackDelay) begin
        mem_ack = 1'b1;
        main_memory_data = memWord(RAM_address);
        reqCycles = 0;
      end
    end else begin
      reqCycles = 0;
    end
  end

  // Per-cycle comparison of outputs against the model.
  initial forever begin
    exp_t e;
    @(negedge clock);
    if (search_done) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("latency", 64'(cyc - e.acceptCyc), e.hit ? 64'd2 : 64'(2 + e.delay));
        lastHit  = e.hit;
        lastData = memWord(e.addr);
        lastTag  = e.addr[31:4];
        if (e.hit) modelHits++;
        else modelMisses++;
      end
    end
    checkOutput("hit", hit, lastHit);
    checkOutput("data", data, lastData);
    checkOutput("tag_out", tag_out, lastTag);
    checkOutput("hit_count", hit_count, 64'(modelHits));
    checkOutput("miss_count", miss_count, 64'(modelMisses));
    if (mem_req) begin
      if (expQ.size() == 0 || expQ[0].hit) checkOutput("spurious_mem_req", 1, 0);
      else checkOutput("RAM_address", RAM_address, expQ[0].addr);
    end
  end

  // Called at a negedge; issues one lookup once ready and records its prediction.
  task automatic issueRead(input logic [31:0] a);
    exp_t e;
    int   n;
    n = 0;
    while (!ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!ready) begin
      checkOutput("ready_timeout", 0, 1);
      return;
    end
    search_cache = 1'b1;
    address      = a;
    e.addr       = a;
    e.hit        = modelAccess(a);
    e.acceptCyc  = cyc;
    e.delay      = ackDelay;
    expQ.push_back(e);
    @(negedge clock);
    search_cache = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (expQ.size() != 0) begin
      checkOutput("done_timeout", 0, 1);
      expQ.delete();
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a);
    issueRead(a);
    waitIdle();
  endtask

  task automatic waitMemReq();
    int n;
    n = 0;
    while (!mem_req && n < 50) begin
      @(negedge clock);
      n++;
    end
    checkOutput("mem_req_seen", mem_req, 1);
  endtask

  task automatic doFlush(input bit withSearch);
    int n;
    n = 0;
    while (!ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    flush        = 1'b1;
    search_cache = withSearch;
    address      = 32'd21;
    modelClear();
    @(negedge clock);
    flush        = 1'b0;
    search_cache = 1'b0;
    n = 0;
    while (!ready && n < 100) begin
      n++;
      @(negedge clock);
    end
    checkOutput("flush_ready_low_cycles", 64'(n), 64'd16);
  endtask

  initial begin
    modelClear();
    #1 reset = 1'b0;
    #2;
    checkOutput("rst_ready", ready, 1);
    checkOutput("rst_search_done", search_done, 0);
    checkOutput("rst_hit", hit, 0);
    checkOutput("rst_data", data, 0);
    checkOutput("rst_tag_out", tag_out, 0);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_RAM_address", RAM_address, 0);
    checkOutput("rst_hit_count", hit_count, 0);
    checkOutput("rst_miss_count", miss_count, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Cold miss then rehit of address 5.
    issueRead(32'd5);
    waitMemReq();
    checkOutput("cold_RAM_address", RAM_address, 32'd5);
    waitIdle();
    checkOutput("cold_hit", hit, 0);
    checkOutput("cold_data", data, 64'd25);
    checkOutput("cold_miss_count", miss_count, 1);
    applyStimulus(32'd5);
    checkOutput("rehit_hit", hit, 1);
    checkOutput("rehit_data", data, 64'd25);
    checkOutput("rehit_hit_count", hit_count, 1);

    // 21 and 37 share set 5 with 5; 37 must evict 5.
    applyStimulus(32'd21);
    applyStimulus(32'd37);
    applyStimulus(32'd21);
    checkOutput("set5_21_hit", hit, 1);
    checkOutput("set5_21_data", data, 64'd441);
    applyStimulus(32'd5);
    checkOutput("set5_5_evicted", hit, 0);

    // Flush wins over a simultaneous lookup; afterwards 21 must miss.
    doFlush(1'b1);
    applyStimulus(32'd21);
    checkOutput("postflush_21_hit", hit, 0);

    // Slow memory; lookup and flush pulses during refill are ignored.
    ackDelay = 7;
    issueRead(32'h100);
    for (int i = 0; i < 3; i++) begin
      search_cache = 1'b1;
      flush        = (i == 1);
      address      = $urandom;
      @(negedge clock);
      search_cache = 1'b0;
      flush        = 1'b0;
      @(negedge clock);
    end
    waitIdle();
    checkOutput("slow_data", data, memWord(32'h100));

    // Reset in the middle of a refill.
    ackDelay = 6;
    issueRead(32'd77);
    waitMemReq();
    #2;
    reset = 1'b0;
    expQ.delete();
    modelClear();
    modelHits   = 0;
    modelMisses = 0;
    lastHit     = 1'b0;
    lastData    = '0;
    lastTag     = '0;
    #1;
    checkOutput("midrst_mem_req", mem_req, 0);
    checkOutput("midrst_search_done", search_done, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("postrst_ready", ready, 1);
    ackDelay = 1;
    applyStimulus(32'd77);
    checkOutput("postrst_77_hit", hit, 0);
    checkOutput("postrst_miss_count", miss_count, 1);

    // Randomized traffic over a small address pool to force hits and evictions.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        doFlush(bit'($urandom_range(0, 1)));
      end else begin
        ackDelay = $urandom_range(1, 4);
        applyStimulus((32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 3)));
      end
    end

    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/assoc_cache.md
ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 SHALL have parameter ADDR_W, 32, word-address width.
REQ-002 SHALL have parameter DATA_W, 64, line/data width (one word per line).
REQ-003 SHALL have parameter NUM_SETS, 16, set count (power of 2, >=2); IDX_W=log2(NUM_SETS), TAG_W=ADDR_W-IDX_W.
REQ-004 SHALL have parameter NUM_WAYS, 2, associativity (power of 2, 1..8).
REQ-005 SHALL have port clock, input, 1, sole clock; all state on posedge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port search_cache, input, 1, lookup request, accepted only when ready=1.
REQ-008 SHALL have port address, input, ADDR_W, lookup word address, sampled on acceptance.
REQ-009 SHALL have port flush, input, 1, invalidate-all request, accepted only when ready=1.
REQ-010 SHALL have port ready, output, 1, high only in IDLE.
REQ-011 SHALL have port search_done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port hit, output, 1, result of completed lookup; valid with search_done.
REQ-013 SHALL have port data, output, DATA_W, returned word; valid with search_done.
REQ-014 SHALL have port tag_out, output, TAG_W, tag of completed lookup.
REQ-015 SHALL have ports mem_req (out, 1), RAM_address (out, ADDR_W), main_memory_data (in, DATA_W), mem_ack (in, 1): refill handshake.
REQ-016 SHALL have ports hit_count, miss_count, output, 32, saturating statistics.

Function
REQ-017 SHALL split address as index=address[IDX_W-1:0], tag=address[ADDR_W-1:IDX_W].
REQ-018 SHALL implement states IDLE, LOOKUP, REFILL, FLUSH.
REQ-019 IDLE: flush=1 -> FLUSH (flush wins over simultaneous search_cache); else search_cache=1 -> LOOKUP, capturing address.
REQ-020 LOOKUP (one cycle): tag match on valid way -> search_done=1, hit=1, data=way data in following cycle, return IDLE; else -> REFILL.
REQ-021 Hit latency SHALL be exactly 2 clock edges from acceptance edge to search_done high.
REQ-022 REFILL: mem_req=1, RAM_address=captured address, held stable until mem_ack sampled high; any latency >=1 cycle legal.
REQ-023 On mem_ack edge: write tag/data/valid into victim way, drop mem_req, next cycle search_done=1, hit=0, data=main_memory_data, return IDLE.
REQ-024 Victim SHALL be lowest-index invalid way, else way with maximum LRU age.
REQ-025 LRU per set: ages 0..NUM_WAYS-1 unique; on hit or refill, accessed way age=0, ways younger than its old age increment by 1, others unchanged.
REQ-026 FLUSH: clear valid and reset ages (way w age=w) of set 0..NUM_SETS-1, one set per cycle, then IDLE; ready=0 for exactly NUM_SETS cycles.
REQ-027 search_cache/flush while ready=0 SHALL be ignored, not queued.
REQ-028 hit_count/miss_count SHALL increment on each hit/miss completion, saturate at 32'hFFFF_FFFF, not cleared by flush.
REQ-029 data/tag_out/hit SHALL hold last completed values between pulses.
REQ-030 NUM_WAYS=1 SHALL behave as direct-mapped with no LRU storage.

Reset
REQ-031 reset low SHALL immediately force IDLE, all valid=0, ages way w=w, ready=1 after release, search_done=0, hit=0, data=0, tag_out=0, mem_req=0, RAM_address=0, counters=0.
REQ-032 reset mid-REFILL SHALL drop mem_req asynchronously and discard the pending line; no search_done.

Structure
REQ-033 SHALL use package assoc_cache_pkg holding state enum and default parameter constants.
REQ-034 SHALL instantiate one sub-module assoc_cache_lru per set (age update and victim select), or a single shared instance on the indexed set.
REQ-035 Tag/data/valid arrays SHALL be flop arrays, no SRAM macros.

Verification (NUM_SETS=16, NUM_WAYS=2, memory word[i]=i*i, mem_ack 1 cycle after mem_req)
REQ-036 Cold read address 5 -> mem_req, RAM_address=5; search_done, hit=0, data=25, miss_count=1.
REQ-037 Reread address 5 -> search_done 2 edges after accept, hit=1, data=25, no mem_req, hit_count=1.
REQ-038 Read 5, 21, 37 (all set 5), then 21 -> 37 evicts 5 (LRU), 21 hits with data=441, reread 5 misses.
REQ-039 flush after warm-up -> ready low 16 cycles; next read of 21 -> hit=0.
REQ-040 mem_ack delayed 7 cycles -> mem_req and RAM_address stable throughout; search_cache pulses meanwhile ignored.
REQ-041 reset low during REFILL -> mem_req=0 immediately; after release, same address misses again.
